// File: rtl/reg_cmd_sequencer.sv
// Command front-end for the 8x16 register-control bank: FIFO-buffers register commands and
// replays each IN/MOVE as an isolated one-cycle strobe followed by a fixed idle gap.
module reg_cmd_sequencer #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 4,
    parameter int ISSUE_GAP = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W+7:0] cmd_word,
    output logic [2:0]        cmd_src,
    output logic [2:0]        cmd_dest,
    output logic              cmd_move,
    output logic              cmd_in,
    output logic [DATA_W-1:0] cmd_data,
    output logic              idle,
    output logic [7:0]        err_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = DATA_W + 8;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [3:0]       GAP_LOAD = 4'(ISSUE_GAP);

    localparam logic [1:0] OP_IN   = 2'b01;
    localparam logic [1:0] OP_MOVE = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        gap_r;
    logic [3:0]        gap_s;
    logic [1:0]        op_r;
    logic [1:0]        op_s;
    logic [2:0]        src_r;
    logic [2:0]        dest_r;
    logic [DATA_W-1:0] data_r;
    logic              move_r;
    logic              in_r;
    logic [7:0]        err_r;

    logic              push_s;
    logic              pop_s;
    logic              load_s;
    logic              err_inc_s;
    logic              move_s;
    logic              in_s;
    logic [WORD_W-1:0] head_s;
    logic [1:0]        head_op_s;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
    assign cmd_ready = (count_r != FULL_CNT);
    assign push_s    = cmd_valid && cmd_ready;
    assign head_s    = mem_r[rd_ptr_r];
    assign head_op_s = head_s[WORD_W-1 -: 2];

    assign idle      = (state_r == S_IDLE) && (count_r == CNT_ZERO);
    assign cmd_src   = src_r;
    assign cmd_dest  = dest_r;
    assign cmd_data  = data_r;
    assign cmd_move  = move_r;
    assign cmd_in    = in_r;
    assign err_cnt   = err_r;

    // Command FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= cmd_word;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (!push_s && pop_s) begin
                count_r <= count_r - CNT_ONE;
            end
        end
    end

    // Next-state and decode: only S_IDLE consumes the FIFO head
    always_comb begin
        state_s   = state_r;
        gap_s     = gap_r;
        op_s      = op_r;
        pop_s     = 1'b0;
        load_s    = 1'b0;
        err_inc_s = 1'b0;
        move_s    = 1'b0;
        in_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (count_r != CNT_ZERO) begin
                    pop_s = 1'b1;
                    case (head_op_s)
                        OP_IN, OP_MOVE: begin
                            load_s  = 1'b1;
                            op_s    = head_op_s;
                            state_s = S_ISSUE;
                        end
                        OP_ILL:  err_inc_s = 1'b1;
                        default: err_inc_s = 1'b0;
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                in_s    = (op_r == OP_IN);
                move_s  = (op_r == OP_MOVE);
                gap_s   = GAP_LOAD;
                state_s = S_GAP;
            end
            S_GAP: begin
                gap_s = gap_r - 4'd1;
                if (gap_r == 4'd1) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_GAP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Sequencer state, issued-command registers, strobes and error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            gap_r   <= 4'd0;
            op_r    <= 2'b00;
            src_r   <= 3'd0;
            dest_r  <= 3'd0;
            data_r  <= '0;
            move_r  <= 1'b0;
            in_r    <= 1'b0;
            err_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            gap_r   <= gap_s;
            op_r    <= op_s;
            move_r  <= move_s;
            in_r    <= in_s;
            if (load_s) begin
                src_r  <= head_s[DATA_W+5:DATA_W+3];
                dest_r <= head_s[DATA_W+2:DATA_W];
                data_r <= head_s[DATA_W-1:0];
            end
            if (err_inc_s) begin
                err_r <= sat_inc8(err_r);
            end
        end
    end

endmodule
